uart_tx_framer: RTL
===================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving payload bits per frame.
REQ-002 Port i_clk SHALL be an input of width 1: the bit clock (divided baud clock); one frame bit per i_clk cycle.
REQ-003 Port i_rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-004 Port i_data SHALL be an input of width DATA_WIDTH: the payload, sampled only on acceptance.
REQ-005 Port i_data_valid SHALL be an input of width 1: the payload request.
REQ-006 Port i_par_en SHALL be an input of width 1: 1 = parity bit appended; sampled on acceptance.
REQ-007 Port i_par_typ SHALL be an input of width 1: 0 = even, 1 = odd; sampled on acceptance.
REQ-008 Port o_tx SHALL be an output of width 1: the registered serial line, idle high.
REQ-009 Port o_busy SHALL be an output of width 1: registered; high while start, data or parity bits are on o_tx.
REQ-010 Port o_frame_done SHALL be an output of width 1: a registered one-cycle pulse during the stop-bit cycle.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, all updated on posedge i_clk.
REQ-012 Acceptance SHALL occur on an edge where the state is IDLE or STOP and i_data_valid=1; i_data, i_par_en and i_par_typ are latched into internal registers.
REQ-013 On acceptance the FSM SHALL transition to START; o_tx=0 and o_busy=1 for the following cycle (latency 1 cycle from valid to start bit).
REQ-014 START SHALL be followed by DATA for exactly DATA_WIDTH cycles, sending bits LSB first from the latched shift register.
REQ-015 A bit counter SHALL have width ceil(log2(DATA_WIDTH)); DATA exits after count DATA_WIDTH-1, and the counter clears on exit with no wrap-around carry into the next frame.
REQ-016 DATA SHALL go to PARITY if the latched par_en=1, otherwise to STOP.
REQ-017 In PARITY, o_tx SHALL equal XOR-reduce(latched data) for even parity, or its inverse for odd parity, for one cycle.
REQ-018 In STOP, o_tx=1, o_busy=0 and o_frame_done=1 SHALL hold for one cycle.
REQ-019 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-020 From STOP, the FSM SHALL go to START if i_data_valid=1 (back-to-back, no idle gap), otherwise to IDLE.
REQ-021 In IDLE, o_tx=1, o_busy=0 and o_frame_done=0 SHALL hold.
REQ-022 i_data_valid in START, DATA or PARITY SHALL be ignored (no queueing); changes on i_data, i_par_en or i_par_typ mid-frame SHALL have no effect on the frame in flight.
REQ-023 o_busy SHALL be usable by the producer as backpressure: holding valid until o_busy falls guarantees acceptance in STOP or IDLE.

Reset
REQ-024 When i_rst=1 on an edge: state=IDLE, o_tx=1, o_busy=0, o_frame_done=0, bit counter=0, shift register=0, latched parity config=0.
REQ-025 Reset SHALL take priority over acceptance and over any state, including mid-frame; the partial frame is abandoned and o_tx returns high on the next cycle.
REQ-026 The first acceptance after reset release SHALL be possible on the first edge with i_rst=0.

Verification
REQ-027 Payload 0xA5 with par_en=0, single valid pulse -> o_tx = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; o_busy high for 9 cycles; o_frame_done in cycle 10.
REQ-028 Payload 0xA5 with par_en=1 and even parity -> parity bit 0; payload 0x07 -> even parity bit 1 and odd parity bit 0; frame is 11 cycles.
REQ-029 Valid held high with 0x3C then 0xC3 -> second start bit immediately follows the first stop bit; 20 contiguous cycles with no idle high.
REQ-030 Valid pulsed and i_data changed during DATA of a 0x55 frame -> the 0x55 frame is unchanged and no extra frame is produced.
REQ-031 i_rst asserted at data bit 4 -> next cycle o_tx=1, o_busy=0; a new valid after release yields a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// One frame bit per i_clk cycle; all outputs registered.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit_q;

  // Next shift register contents while walking the data bits.
  assign sh_nxt = shreg >> 1;

  // Frame sequencer; the line outputs are registered with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE, STOP: begin
          o_frame_done <= 1'b0;
          cnt          <= '0;
          if (i_data_valid) begin
            shreg     <= i_data;
            par_en_q  <= i_par_en;
            par_typ_q <= i_par_typ;
            par_bit_q <= ^i_data;
            state     <= START;
            o_tx      <= 1'b0;
            o_busy    <= 1'b1;
          end else begin
            state  <= IDLE;
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          o_tx   <= shreg[0];
          o_busy <= 1'b1;
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (par_en_q) begin
              state  <= PARITY;
              o_tx   <= par_bit_q ^ par_typ_q;
              o_busy <= 1'b1;
            end else begin
              state        <= STOP;
              o_tx         <= 1'b1;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
            end
          end else begin
            cnt    <= cnt + CW'(1);
            shreg  <= sh_nxt;
            o_tx   <= sh_nxt[0];
            o_busy <= 1'b1;
          end
        end
        PARITY: begin
          state        <= STOP;
          o_tx         <= 1'b1;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          o_tx         <= 1'b1;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
